// File: rtl/my_trame_axil_regbank.sv
// AXI4-Lite slave register bank: C_NUM_REGS registers, optional read-only status slots, SLVERR decode.
// Define MY_TRAME_WR_PULSE_EN to add the per-register wr_pulse output.
module my_trame_axil_regbank #(
  parameter int                    C_S_AXI_DATA_WIDTH = 32,
  parameter int                    C_S_AXI_ADDR_WIDTH = 6,
  parameter int                    C_NUM_REGS         = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
  input  logic                                       S_AXI_ACLK,
  input  logic                                       S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                                 S_AXI_AWPROT,
  input  logic                                       S_AXI_AWVALID,
  output logic                                       S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                       S_AXI_WVALID,
  output logic                                       S_AXI_WREADY,
  output logic [1:0]                                 S_AXI_BRESP,
  output logic                                       S_AXI_BVALID,
  input  logic                                       S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                                 S_AXI_ARPROT,
  input  logic                                       S_AXI_ARVALID,
  output logic                                       S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                                 S_AXI_RRESP,
  output logic                                       S_AXI_RVALID,
  input  logic                                       S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   status_in
`ifdef MY_TRAME_WR_PULSE_EN
  ,
  output logic [C_NUM_REGS-1:0]                      wr_pulse
`endif
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IW       = AW - ADDR_LSB;

  localparam logic [1:0] WR_IDLE = 2'd0, WR_WAIT = 2'd1, WR_RESP = 2'd2;
  localparam logic       RD_IDLE = 1'b0, RD_RESP = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  logic            rst_done_q;
  logic [1:0]      wr_state_q, wr_state_d;
  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rd_state_q, rd_state_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   regs_q [C_NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_hit;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data, rd_val;
  logic [SW-1:0]         wr_strb;
  logic [IW-1:0]         wr_idx, ar_idx;
  logic [C_NUM_REGS-1:0] wr_sel;
  logic                  unused_sig;

  // Readies stay low until the first edge that samples reset released.
  assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_AWREADY = rst_done_q && !aw_held_q && !S_AXI_BVALID;
  assign S_AXI_WREADY  = rst_done_q && !w_held_q && !S_AXI_BVALID;
  assign S_AXI_RVALID  = (rd_state_q == RD_RESP);
  assign S_AXI_ARREADY = rst_done_q && !S_AXI_RVALID;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign wr_addr = aw_held_q ? awaddr_q : S_AXI_AWADDR;
  assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;
  assign wr_idx  = wr_addr[AW-1:ADDR_LSB];
  assign ar_idx  = S_AXI_ARADDR[AW-1:ADDR_LSB];
  assign commit  = (wr_state_q != WR_RESP) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_ok   = |wr_sel;

  assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, status_in,
                        wr_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_sel = '0;
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      wr_sel[i] = (wr_idx == IW'(i)) && !C_RO_MASK[i];
      if (ar_idx == IW'(i)) begin
        rd_hit = 1'b1;
        rd_val = C_RO_MASK[i] ? status_in[i*DW +: DW] : regs_q[i];
      end
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q || aw_hs;
    w_held_d   = w_held_q || w_hs;
    awaddr_d   = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wdata_d    = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d    = w_hs ? S_AXI_WSTRB : wstrb_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      WR_RESP: if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      default: begin
        if (commit) begin
          wr_state_d = WR_RESP;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (aw_held_d || w_held_d) begin
          wr_state_d = WR_WAIT;
        end
      end
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    if (ar_hs) begin
      rd_state_d = RD_RESP;
      rdata_d    = rd_hit ? rd_val : '0;
      rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      rd_state_d = RD_IDLE;
    end
  end

  // NOTE: the register file is reset explicitly because software relies on it reading zero after reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rst_done_q <= 1'b0;
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      rst_done_q <= 1'b1;
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        for (int b = 0; b < SW; b++) begin
          if (commit && wr_sel[i] && wr_strb[b]) regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = C_RO_MASK[g] ? '0 : regs_q[g];
  end

`ifdef MY_TRAME_WR_PULSE_EN
  logic [C_NUM_REGS-1:0] wr_pulse_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) wr_pulse_q <= '0;
    else                wr_pulse_q <= commit ? wr_sel : '0;
  end

  assign wr_pulse = wr_pulse_q;
`endif

endmodule
